uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Round-robin scheduler that shares one UART byte transmitter among N_REQ byte sources, for example the scope's sample streamer, status reporter and command echo. It takes one byte from the granted source and issues a one-cycle Send_En with Data_Byte to the transmitter. It waits for Tx_Done, signals per-channel completion, enforces an inter-byte gap, and recovers via a watchdog if Tx_Done never arrives.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_W, 8, byte width
TIMEOUT_CYC, 65535, max Clk cycles in WAIT before abort (covers 9600 bps at 50 MHz: 52080 cycles per 10-bit frame); counter is 20 bits
GAP_CYC, 2, idle cycles after each byte before the next arbitration (0 is treated as 1)

Ports:
Clk  in  1  system clock, 50 MHz
Rst_n  in  1  asynchronous reset, active-low
Req  in  N_REQ  per-channel byte request, level
Req_Data  in  N_REQ*DATA_W  flattened bytes; channel i at [i*DATA_W +: DATA_W]
Grant  out  N_REQ  one-hot, 1-cycle pulse; the channel's byte has been latched
Done  out  N_REQ  one-hot, 1-cycle pulse; the channel's byte has been transmitted
Send_En  out  1  1-cycle start pulse to the transmitter
Data_Byte  out  DATA_W  byte to the transmitter, held until the next Grant
Tx_Done  in  1  1-cycle completion pulse from the transmitter
Uart_Busy  out  1  high whenever state != IDLE
Timeout_Err  out  1  1-cycle pulse when the watchdog aborts a byte

Behaviour:
- All outputs are registered.
- Reset values: Grant=0, Done=0, Send_En=0, Data_Byte=0, Uart_Busy=0, Timeout_Err=0; state=IDLE; last-grant pointer=N_REQ-1 (channel 0 has first priority); timers=0.
- Reset asserted mid-operation aborts immediately: no Done or Timeout_Err is issued. The transmitter shares Rst_n.
- FSM states: IDLE, START, WAIT, GAP.
- IDLE with Req==0: stay.
- IDLE with Req!=0: select the first set bit scanning last+1, last+2, ... wrapping modulo N_REQ. On that edge: Grant[sel]<=1, Data_Byte<=Req_Data[sel], cur<=sel, last<=sel, go to START.
- START: Send_En<=1 for exactly one cycle; clear the timer; go to WAIT.
- WAIT, Tx_Done=1: Done[cur]<=1; go to GAP.
- WAIT, timer==TIMEOUT_CYC-1 and Tx_Done=0: Timeout_Err<=1, no Done; go to GAP.
- WAIT, otherwise: timer+1.
- WAIT, Tx_Done and timeout in the same cycle: Tx_Done wins, no error.
- GAP: stay max(GAP_CYC,1) cycles, then go to IDLE. Requests are not sampled during GAP.
- Latency: Req sampled at edge t in IDLE gives Grant high in cycle t+1 and Send_En high in cycle t+2.
- Minimum byte-to-byte spacing is Tx_Done, then GAP, then IDLE, then START, so the transmitter's baud generator always sees a fresh Send_En after it returns to idle.
- Requester rules:
  - Hold Req and Req_Data stable until Grant.
  - Data is captured on the Grant edge; Req_Data may change afterwards.
  - Req still high after Grant means another byte; it is re-arbitrated fairly.
  - Dropping Req before Grant withdraws the request without error.
- Tx_Done in IDLE, START or GAP is ignored.
- Grant and Done are never both high in the same cycle.
- At most one Grant is outstanding at any time.

Test Plan:
1. Only Req[1] with Req_Data ch1=8'hA5 → Grant=4'b0010 one cycle later, Send_En the next cycle, Data_Byte=8'hA5. Tx_Done after 20 cycles → Done=4'b0010; Uart_Busy falls after GAP.
2. Req=4'b1111 held, bytes 11/22/33/44, Tx_Done model 10 cycles → Grant order 0,1,2,3,0,1,…; Send_En/Done pairs match; Data_Byte sequence 11,22,33,44.
3. Req[0] and Req[2] held continuously → grants alternate 0,2,0,2; channel 1 and 3 never granted; no starvation over 8 bytes.
4. TIMEOUT_CYC=100, Tx_Done never asserted → Timeout_Err exactly 100 cycles after Send_En, no Done. A following Req[3] is served normally; the next round-robin pick after ch0 skips ch0.
5. Tx_Done pulses while IDLE and during GAP → no Done and no state change. Tx_Done coincident with the timeout cycle → Done issued, Timeout_Err=0.
6. Rst_n low mid-WAIT → all outputs 0 asynchronously. After release with Req=4'b1001, channel 0 is granted first.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin scheduler sharing one UART byte transmitter among N_REQ sources
//
// Ports:
//   Clk          system clock
//   Rst_n        asynchronous reset, active-low
//   Req          per-channel byte request (level, held until Grant)
//   Req_Data     flattened request bytes, channel i at [i*DATA_W +: DATA_W]
//   Grant        one-hot 1-cycle pulse: that channel's byte has been latched
//   Done         one-hot 1-cycle pulse: that channel's byte has been transmitted
//   Send_En      1-cycle start pulse to the transmitter
//   Data_Byte    byte presented to the transmitter, held until the next Grant
//   Tx_Done      1-cycle completion pulse from the transmitter
//   Uart_Busy    high whenever the scheduler is not idle
//   Timeout_Err  1-cycle pulse when the watchdog abandons a byte
module uart_tx_arbiter #(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 65535,
    parameter int GAP_CYC     = 2
) (
    input  logic                      Clk,
    input  logic                      Rst_n,
    input  logic [N_REQ-1:0]          Req,
    input  logic [N_REQ*DATA_W-1:0]   Req_Data,
    output logic [N_REQ-1:0]          Grant,
    output logic [N_REQ-1:0]          Done,
    output logic                      Send_En,
    output logic [DATA_W-1:0]         Data_Byte,
    input  logic                      Tx_Done,
    output logic                      Uart_Busy,
    output logic                      Timeout_Err
);

    localparam int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    // A zero gap would let IDLE follow WAIT directly; one idle cycle minimum.
    localparam int GAP_EFF = (GAP_CYC < 1) ? 1 : GAP_CYC;
    localparam int GAP_W   = $clog2(GAP_EFF + 1);

    localparam logic [19:0]      TIMER_LAST = 20'(TIMEOUT_CYC - 1);
    localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(GAP_EFF - 1);
    localparam logic [IDX_W-1:0] IDX_RESET  = IDX_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_GAP
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   last_idx;
    logic [IDX_W-1:0]   cur_idx;
    logic [19:0]        timer;
    logic [GAP_W-1:0]   gap_cnt;

    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;

    // Round-robin pick: first asserted request scanning upward from the
    // channel after the last one granted, wrapping around.
    always_comb begin
        logic [IDX_W-1:0] probe;
        pick_idx   = '0;
        pick_valid = 1'b0;
        probe      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            probe = IDX_W'((int'(last_idx) + k) % N_REQ);
            if (!pick_valid && Req[probe]) begin
                pick_idx   = probe;
                pick_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state       <= ST_IDLE;
            last_idx    <= IDX_RESET;
            cur_idx     <= '0;
            timer       <= '0;
            gap_cnt     <= '0;
            Grant       <= '0;
            Done        <= '0;
            Send_En     <= 1'b0;
            Data_Byte   <= '0;
            Uart_Busy   <= 1'b0;
            Timeout_Err <= 1'b0;
        end else begin
            // Pulse outputs default low; each branch raises what it needs.
            Grant       <= '0;
            Done        <= '0;
            Send_En     <= 1'b0;
            Timeout_Err <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        Grant[pick_idx] <= 1'b1;
                        Data_Byte       <= Req_Data[int'(pick_idx)*DATA_W +: DATA_W];
                        cur_idx         <= pick_idx;
                        last_idx        <= pick_idx;
                        Uart_Busy       <= 1'b1;
                        state           <= ST_START;
                    end
                end

                ST_START: begin
                    Send_En <= 1'b1;
                    timer   <= '0;
                    state   <= ST_WAIT;
                end

                ST_WAIT: begin
                    // Completion takes priority over a watchdog expiring on
                    // the same cycle.
                    if (Tx_Done) begin
                        Done[cur_idx] <= 1'b1;
                        gap_cnt       <= '0;
                        state         <= ST_GAP;
                    end else if (timer == TIMER_LAST) begin
                        Timeout_Err <= 1'b1;
                        gap_cnt     <= '0;
                        state       <= ST_GAP;
                    end else begin
                        timer <= timer + 20'd1;
                    end
                end

                ST_GAP: begin
                    // Requests are not looked at here; Tx_Done is ignored.
                    if (gap_cnt == GAP_LAST) begin
                        Uart_Busy <= 1'b0;
                        state     <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end

                default: begin
                    Uart_Busy <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - randomized self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int TO  = 100;
    localparam int GAP = 2;

    logic            Clk = 1'b0;
    logic            Rst_n;
    logic [N-1:0]    Req;
    logic [N*DW-1:0] Req_Data;
    logic [N-1:0]    Grant;
    logic [N-1:0]    Done;
    logic            Send_En;
    logic [DW-1:0]   Data_Byte;
    logic            Tx_Done;
    logic            Uart_Busy;
    logic            Timeout_Err;

    uart_tx_arbiter #(
        .N_REQ       (N),
        .DATA_W      (DW),
        .TIMEOUT_CYC (TO),
        .GAP_CYC     (GAP)
    ) dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .Req         (Req),
        .Req_Data    (Req_Data),
        .Grant       (Grant),
        .Done        (Done),
        .Send_En     (Send_En),
        .Data_Byte   (Data_Byte),
        .Tx_Done     (Tx_Done),
        .Uart_Busy   (Uart_Busy),
        .Timeout_Err (Timeout_Err)
    );

    always #5 Clk = ~Clk;

    int total    = 0;
    int bad      = 0;
    int cyc      = 0;
    int last_ch  = N - 1;
    int prev_end = -1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge Clk);
        cyc++;
    endtask

    function automatic int rr_pick(input int last, input logic [N-1:0] r);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    // One byte: wait for the Grant, act as the transmitter (Tx_Done after
    // 'delay' cycles from the Send_En cycle, never if outside 0..TO-1),
    // then watch the gap with stray Tx_Done pulses.
    task automatic xfer(input int delay, input logic [N-1:0] next_req,
                        input bit chk_gap, input bit scramble);
        int            exp_ch;
        int            g;
        int            s;
        int            e;
        bit            got;
        logic [DW-1:0] exp_byte;
        exp_ch   = rr_pick(last_ch, Req);
        exp_byte = (exp_ch >= 0) ? Req_Data[exp_ch*DW +: DW] : '0;
        got      = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            tick();
            Tx_Done = 1'b0;
            if (Grant != '0) got = 1'b1;
        end
        if (!got) begin
            check_eq("grant_wait", 0, 1);
            return;
        end
        g = cyc;
        check_eq("grant_vec", Grant, 32'(1) << exp_ch);
        check_eq("grant_byte", Data_Byte, exp_byte);
        check_eq("grant_busy", Uart_Busy, 1);
        if (chk_gap && prev_end >= 0) check_eq("grant_spacing", g - prev_end, GAP + 1);
        last_ch  = exp_ch;
        Req      = next_req;
        if (scramble) Req_Data = $urandom;
        Tx_Done  = 1'($urandom_range(0, 1));
        tick();
        s = cyc;
        check_eq("send_en", {Send_En, Grant, Done}, {1'b1, 8'b0});
        check_eq("send_byte", Data_Byte, exp_byte);
        e = -1;
        for (int k = 0; k <= TO + 5 && e < 0; k++) begin
            Tx_Done = (k == delay);
            tick();
            if (Done != '0 || Timeout_Err) e = cyc;
        end
        Tx_Done = 1'b0;
        if (e < 0) begin
            check_eq("end_wait", 0, 1);
            return;
        end
        if (delay >= 0 && delay < TO) begin
            check_eq("done_vec", Done, 32'(1) << exp_ch);
            check_eq("done_no_err", Timeout_Err, 0);
            check_eq("done_lat", e - s, delay + 1);
        end else begin
            check_eq("to_err", Timeout_Err, 1);
            check_eq("to_no_done", Done, 0);
            check_eq("to_lat", e - s, TO);
        end
        check_eq("end_no_grant", Grant, 0);
        for (int j = 1; j <= GAP; j++) begin
            Tx_Done = 1'($urandom_range(0, 1));
            tick();
            check_eq("gap_quiet", {Done, Timeout_Err, Send_En, Grant}, 0);
            check_eq("gap_busy", Uart_Busy, (j < GAP) ? 1 : 0);
        end
        Tx_Done  = 1'($urandom_range(0, 1));
        prev_end = e;
    endtask

    initial begin
        int r;
        int d;
        bit gap_ok;
        Rst_n    = 1'b0;
        Req      = '0;
        Req_Data = '0;
        Tx_Done  = 1'b0;
        tick();
        tick();
        check_eq("rst_outs", {Grant, Done, Send_En, Data_Byte, Uart_Busy, Timeout_Err}, 0);
        Rst_n = 1'b1;
        tick();

        // single requester on channel 1
        Req_Data = 32'h0000_A500;
        Req      = 4'b0010;
        xfer(20, 4'b0000, 1'b0, 1'b0);

        // all four held, fixed bytes
        Req_Data = 32'h4433_2211;
        Req      = 4'b1111;
        repeat (8) xfer(10, 4'b1111, 1'b1, 1'b0);

        // channels 0 and 2 held: strict alternation
        Req = 4'b0101;
        repeat (8) xfer(int'($urandom_range(0, 15)), 4'b0101, 1'b1, 1'b1);

        // watchdog, then normal service and rotation past channel 0
        Req = 4'b0001;
        xfer(-1, 4'b0000, 1'b1, 1'b0);
        Req = 4'b0011;
        xfer(5, 4'b0000, 1'b1, 1'b0);
        Req = 4'b1000;
        xfer(7, 4'b0000, 1'b1, 1'b0);

        // Tx_Done on the watchdog's last cycle wins
        Req = 4'b0100;
        xfer(TO - 1, 4'b0010, 1'b1, 1'b0);

        // request held through the gap then withdrawn; stray Tx_Done in IDLE
        Req = 4'b0000;
        repeat (6) begin
            tick();
            check_eq("idle_quiet", {Grant, Done, Send_En, Timeout_Err, Uart_Busy}, 0);
            Tx_Done = 1'($urandom_range(0, 1));
        end
        Tx_Done = 1'b0;

        // asynchronous reset in WAIT
        Req = 4'b0100;
        for (int i = 0; i < 20 && !Send_En; i++) tick();
        check_eq("pre_rst_send", Send_En, 1);
        repeat (3) tick();
        #2 Rst_n = 1'b0;
        #1 check_eq("rst_async", {Grant, Done, Send_En, Data_Byte, Uart_Busy, Timeout_Err}, 0);
        Req      = 4'b1001;
        Req_Data = 32'h5A00_00C3;
        #1 Rst_n = 1'b1;
        last_ch  = N - 1;
        prev_end = -1;
        xfer(4, 4'b0000, 1'b0, 1'b0);

        // randomized traffic
        gap_ok = 1'b1;
        repeat (40) begin
            Req      = 4'($urandom_range(1, 15));
            Req_Data = $urandom;
            r        = int'($urandom_range(0, 11));
            if (r == 0)      d = -1;
            else if (r == 1) d = TO - 1;
            else             d = int'($urandom_range(0, 25));
            xfer(d, 4'b0000, gap_ok, 1'b1);
            gap_ok = 1'b1;
            if ($urandom_range(0, 3) == 0) begin
                Req = 4'b0000;
                repeat (int'($urandom_range(1, 4))) begin
                    tick();
                    check_eq("rand_idle", {Grant, Uart_Busy}, 0);
                end
                gap_ok = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end

endmodule
